// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code burst sequencer.
package gray_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Width-agnostic helper; callers cast the result down to their count width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_code_counter_en.sv
// Modulo-MOD_VALUE binary counter with enable and synchronous clear,
// exposing both the binary value and its Gray-coded form.
module gray_code_counter_en
    import gray_seq_pkg::*;
#(
    parameter  int MOD_VALUE = 8,
    localparam int W         = $clog2(MOD_VALUE)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count_binary,
    output logic [W-1:0] gray_count_out
);

    logic [W-1:0] count_q;

    // MOD_VALUE is a power of two, so the natural W-bit wrap is the modulus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_binary   = count_q;
    assign gray_count_out = W'(bin2gray(32'(count_q)));

endmodule

// File: rtl/gray_count_sequencer.sv
// Burst sequencer: accepts a length command and steps a Gray-coded counter
// that many times, with pause, abort and a one-cycle done/aborted report.
module gray_count_sequencer
    import gray_seq_pkg::*;
#(
    parameter  int MOD_VALUE = 8,
    parameter  int LEN_W     = 8,
    localparam int W         = $clog2(MOD_VALUE)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_clr,
    input  logic             pause,
    input  logic             abort,
    output logic [W-1:0]     gray_count_out,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    if (MOD_VALUE < 2 || (MOD_VALUE & (MOD_VALUE - 1)) != 0) begin : g_bad_mod
        $error("gray_count_sequencer: MOD_VALUE must be a power of two >= 2");
    end

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             busy_q, done_q, aborted_q, aborted_d;
    logic             cnt_en, cnt_clr;
    logic [W-1:0]     count_binary;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        aborted_d   = 1'b0;
        cnt_en      = 1'b0;
        cnt_clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cnt_clr = cmd_clr;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = RUN;
                        remaining_d = cmd_len;
                    end
                end
            end
            RUN: begin
                // Abort wins over both pause and the final increment.
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (!pause) begin
                    cnt_en      = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            busy_q      <= (state_d == RUN);
            done_q      <= (state_d == DONE);
            aborted_q   <= aborted_d;
        end
    end

    gray_code_counter_en #(
        .MOD_VALUE(MOD_VALUE)
    ) u_counter (
        .clk           (clk),
        .rstn          (rstn),
        .en            (cnt_en),
        .clr           (cnt_clr),
        .count_binary  (count_binary),
        .gray_count_out(gray_count_out)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Self-checking bench for gray_count_sequencer: directed table, corner-case
// sequences and random stimulus against a transaction-level reference model.
module tb_gray_count_sequencer;

    localparam int MOD_VALUE = 8;
    localparam int LEN_W     = 8;
    localparam int W         = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_clr;
    logic             pause;
    logic             abort;
    logic [W-1:0]     gray_count_out;
    logic             busy;
    logic             done;
    logic             aborted;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle, 1 = running, 2 = reporting done.
    int       m_phase;
    int       m_left;
    int       m_count;
    int       m_ab;
    int       m_inc;
    logic [W-1:0] prev_gray;

    gray_count_sequencer #(
        .MOD_VALUE(MOD_VALUE),
        .LEN_W    (LEN_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_clr       (cmd_clr),
        .pause         (pause),
        .abort         (abort),
        .gray_count_out(gray_count_out),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_left    = 0;
        m_count   = 0;
        m_ab      = 0;
        m_inc     = 0;
        prev_gray = '0;
    endtask

    task automatic model_edge(input int v, input int l, input int c, input int p, input int a);
        m_inc = 0;
        if (m_phase == 0) begin
            if (v != 0) begin
                if (c != 0) m_count = 0;
                if (l == 0) begin
                    m_phase = 2;
                    m_ab    = 0;
                end else begin
                    m_phase = 1;
                    m_left  = l;
                end
            end
        end else if (m_phase == 1) begin
            if (a != 0) begin
                m_phase = 2;
                m_ab    = 1;
            end else if (p == 0) begin
                m_count = (m_count + 1) % MOD_VALUE;
                m_left  = m_left - 1;
                m_inc   = 1;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_ab    = 0;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        chk("gray",         int'(gray_count_out),    gray_of(m_count));
        chk("count_binary", int'(dut.count_binary),  m_count);
        chk("cmd_ready",    int'(cmd_ready),         int'(m_phase == 0));
        chk("busy",         int'(busy),              int'(m_phase == 1));
        chk("done",         int'(done),              int'(m_phase == 2));
        chk("aborted",      int'(aborted),           int'(m_phase == 2 && m_ab != 0));
        if (m_inc != 0)
            chk("one_bit_step", $countones(prev_gray ^ gray_count_out), 1);
        prev_gray = gray_count_out;
    endtask

    task automatic step(input int v, input int l, input int c, input int p, input int a);
        cmd_valid = (v != 0);
        cmd_len   = LEN_W'(l);
        cmd_clr   = (c != 0);
        pause     = (p != 0);
        abort     = (a != 0);
        @(posedge clk);
        model_edge(v, l, c, p, a);
        #1 check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gray"},    int'(gray_count_out),   0);
        chk({tag, "_count"},   int'(dut.count_binary), 0);
        chk({tag, "_ready"},   int'(cmd_ready),        1);
        chk({tag, "_busy"},    int'(busy),             0);
        chk({tag, "_done"},    int'(done),             0);
        chk({tag, "_aborted"}, int'(aborted),          0);
    endtask

    typedef struct {
        int v; int l; int c; int p; int a;
        int g; int rdy; int bsy; int dn; int ab;
    } vec_t;

    vec_t     tbl[12];
    int       edges;
    int       ndone;
    int       q_gray[$];

    initial begin
        // Burst of 5 with clear from reset, then a 6-burst aborted after 2 steps.
        tbl[0]  = '{1, 5, 1, 0, 0,  0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,  3, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0,  2, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0,  6, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0,  7, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0,  7, 1, 0, 0, 0};
        tbl[7]  = '{1, 6, 0, 0, 0,  7, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0,  5, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0,  4, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1,  4, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0,  4, 1, 0, 0, 0};

        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_clr   = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        rstn      = 1'b0;
        model_reset();
        #1 check_reset_outputs("rst");
        @(posedge clk);
        #3 rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].p, tbl[i].a);
            chk($sformatf("tbl%0d_gray", i),  int'(gray_count_out), tbl[i].g);
            chk($sformatf("tbl%0d_ready", i), int'(cmd_ready),      tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i),  int'(busy),           tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i),  int'(done),           tbl[i].dn);
            chk($sformatf("tbl%0d_abort", i), int'(aborted),        tbl[i].ab);
        end

        // Move count from 7 to 6, then a 10-burst that wraps through 7 -> 0.
        step(1, 7, 0, 0, 0);
        for (int i = 0; i < 7; i++) idle();
        chk("pre_wrap_done", int'(done), 1);
        idle();
        chk("pre_wrap_count", int'(dut.count_binary), 6);
        step(1, 10, 0, 0, 0);
        q_gray.push_back(int'(gray_count_out));
        for (int i = 0; i < 10; i++) begin
            idle();
            q_gray.push_back(int'(gray_count_out));
        end
        chk("wrap_g0", q_gray[0], 5);
        chk("wrap_g1", q_gray[1], 4);
        chk("wrap_g2", q_gray[2], 0);
        chk("wrap_final_gray", q_gray[10], 0);
        chk("wrap_done_at_11", int'(done), 1);
        idle();

        // Pause for 3 cycles after the 2nd increment of a 4-burst.
        step(1, 4, 0, 0, 0);
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            chk("pause_hold", int'(dut.count_binary), 2);
        end
        edges = 6;
        while (!done && edges < 20) begin
            idle();
            edges++;
        end
        chk("pause_latency", edges, 8);
        idle();

        // Abort together with pause, abort on the final increment, abort/pause in idle.
        step(0, 0, 0, 1, 1);
        step(1, 3, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("abort_pause_aborted", int'(aborted), 1);
        idle();
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("abort_last_count", int'(dut.count_binary), 4);
        idle();

        // Zero-length commands, with and without clear.
        step(1, 0, 0, 0, 0);
        chk("len0_done", int'(done), 1);
        chk("len0_count", int'(dut.count_binary), 4);
        idle();
        step(1, 0, 1, 0, 0);
        chk("len0_clr_count", int'(dut.count_binary), 0);
        idle();

        // cmd_valid held high: 2-bursts back to back.
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 2, 0, 0, 0);
            if (done) ndone++;
        end
        chk("b2b_done_pulses", ndone, 3);
        idle();
        idle();

        // Asynchronous reset between edges in the middle of a burst.
        step(1, 9, 0, 0, 0);
        idle();
        idle();
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1 check_reset_outputs("held_rst");
        #2 rstn = 1'b1;
        step(1, 3, 1, 0, 0);
        idle();
        idle();
        idle();
        chk("post_rst_done", int'(done), 1);
        chk("post_rst_count", int'(dut.count_binary), 3);
        idle();

        // Random stimulus against the reference model.
        for (int i = 0; i < 600; i++) begin
            step(int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 11) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
